stopwatch_input_ctrl: RTL and testbench
=======================================

Name: stopwatch_input_ctrl

Overview:
- Front end for the stopwatch controller. Runs on one system clock.
- Synchronises and debounces the raw R (reset) and P (pause/run) push-buttons.
- Converts each debounced press into a single event that is held until the controller's next display-rate step, so a long press acts once.
- Generates the two clock-enable strobes the stopwatch needs: count rate (0.01 s) and display-multiplex rate.

Parameters:
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- CNT_DIV, 1000000, clk cycles per c_tick (100 Hz count enable).
- DISP_DIV, 100000, clk cycles per d_tick (1 kHz display/FSM step).

Ports:
- clk  in  1  system clock, 100 MHz, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- btn_r  in  1  raw R button, active-high, asynchronous, bouncy
- btn_p  in  1  raw P button, active-high, asynchronous, bouncy
- r_level  out  1  debounced R level
- p_level  out  1  debounced P level
- r_evt  out  1  R press event, held until consumed at d_tick
- p_evt  out  1  P press event, held until consumed at d_tick
- c_tick  out  1  one-cycle count enable, every CNT_DIV cycles
- d_tick  out  1  one-cycle display/FSM enable, every DISP_DIV cycles

Behaviour:
- Reset: rst_n low asynchronously clears all flops.
  - Synchronisers, levels, events, ticks and all counters go to 0.
  - Every output is 0 during reset and in the first cycle after release.
  - Asserting reset mid-debounce or mid-division discards all progress. Pending events are lost.
- Synchroniser: two-flop chain per button. The debouncer sees only the second flop (s_r, s_p).
- Debounce FSM, one per button. States are RELEASED, WAIT_PRESS, PRESSED, WAIT_REL. The stable counter is ceil(log2(DB_CYCLES)) bits wide.
  - RELEASED: if s=1, go to WAIT_PRESS and set cnt=0.
  - WAIT_PRESS: if s=0, return to RELEASED; otherwise cnt increments. When cnt==DB_CYCLES-1 with s=1, go to PRESSED.
  - PRESSED: if s=0, go to WAIT_REL and set cnt=0.
  - WAIT_REL: if s=1, return to PRESSED; otherwise cnt increments. When cnt==DB_CYCLES-1 with s=0, go to RELEASED.
  - level=1 in PRESSED and WAIT_REL, 0 otherwise. level is registered.
- Glitch rejection: any glitch shorter than DB_CYCLES cycles produces no level change.
- Latency: from a clean edge on btn_x to the level change is 2 sync cycles + DB_CYCLES cycles, +1 registered-output cycle.
- Press detect: a one-cycle internal strobe on the WAIT_PRESS to PRESSED transition. Releases generate no event.
- Event hold (x in r/p):
  - x_evt sets on the cycle after the press strobe.
  - x_evt clears on the cycle after a cycle in which d_tick=1 and x_evt=1, i.e. each event is visible for exactly one d_tick.
  - If a press strobe and the consuming d_tick coincide, the event stays set and is consumed by the following d_tick.
  - A second press while x_evt=1 is absorbed: one event only, no queue.
- R priority:
  - While r_evt=1, p press strobes are discarded.
  - If r and p strobes occur in the same cycle, only r_evt sets.
  - A p_evt already set before r_evt remains and is consumed normally.
- Tick dividers: independent free-running counters, 0..DIV-1, wrapping to 0.
  - The tick is registered, high for exactly one cycle when the counter equals DIV-1.
  - The first c_tick is at cycle CNT_DIV after reset release; it then repeats with period CNT_DIV exactly.
  - The same rules apply to d_tick with DISP_DIV.
  - There is no phase relationship between c_tick and d_tick; coincident ticks are legal.
- Parameters are legal at >=2. Counter widths are derived from the parameter. No overflow beyond DIV-1.

Test Plan (bench overrides DB_CYCLES=4, CNT_DIV=10, DISP_DIV=3):
- Reset then idle 50 cycles:
  - All outputs 0 throughout, except ticks.
  - c_tick pulses at cycles 10, 20, 30, 40, 50.
  - d_tick pulses every 3rd cycle starting at cycle 3.
- btn_p clean high for 20 cycles, then low:
  - p_level rises 7 cycles after the edge and falls 7 cycles after release.
  - Exactly one p_evt is raised, lasting until the cycle after the next d_tick.
- btn_p bounce pattern 1,0,1,1,0,1,1,1,1,1 (then held high):
  - No level change until the final 4-cycle stable run completes.
  - Exactly one p_evt.
- btn_r and btn_p pressed on the same cycle:
  - r_evt=1, p_evt stays 0.
  - Both r_level and p_level go to 1.
- p press strobe aligned so the event's first-set cycle coincides with d_tick:
  - p_evt survives that tick and clears after the next d_tick, 3 cycles later.
- rst_n pulsed low for 1 cycle, asynchronously, mid-WAIT_PRESS with p_evt=1 pending:
  - All outputs are 0 immediately.
  - Tick counters restart; the first c_tick comes 10 cycles after release.

Source files
------------

// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch front end: button synchronisers and debouncers, single-shot press
// events held until the next display step, and the count/display tick dividers.

module stopwatch_input_db #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    output logic level,
    output logic press
);
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        WAIT_PRESS = 2'd1,
        PRESSED    = 2'd2,
        WAIT_REL   = 2'd3
    } db_state_t;

    db_state_t       state, state_n;
    logic [DW-1:0]   cnt, cnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            level <= (state_n == PRESSED) || (state_n == WAIT_REL);
        end
    end

    // press is only raised on the accepted rising edge; releases are silent
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press   = 1'b0;
        case (state)
            RELEASED: begin
                if (s) begin
                    state_n = WAIT_PRESS;
                    cnt_n   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_n = RELEASED;
                end else if (cnt == DB_LAST) begin
                    state_n = PRESSED;
                    press   = 1'b1;
                end else begin
                    cnt_n = cnt + DW'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n = WAIT_REL;
                    cnt_n   = '0;
                end
            end
            WAIT_REL: begin
                if (s) begin
                    state_n = PRESSED;
                end else if (cnt == DB_LAST) begin
                    state_n = RELEASED;
                end else begin
                    cnt_n = cnt + DW'(1);
                end
            end
            default: state_n = RELEASED;
        endcase
    end
endmodule

module stopwatch_input_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_DIV   = 1000000,
    parameter int DISP_DIV  = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_r,
    input  logic btn_p,
    output logic r_level,
    output logic p_level,
    output logic r_evt,
    output logic p_evt,
    output logic c_tick,
    output logic d_tick
);
    localparam int CW = $clog2(CNT_DIV);
    localparam int DDW = $clog2(DISP_DIV);
    localparam logic [CW-1:0]  C_LAST = CW'(CNT_DIV - 1);
    localparam logic [DDW-1:0] D_LAST = DDW'(DISP_DIV - 1);

    logic r_meta, s_r, p_meta, s_p;
    logic r_press, p_press, p_take;
    logic [CW-1:0]  c_cnt;
    logic [DDW-1:0] d_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            s_r    <= 1'b0;
            p_meta <= 1'b0;
            s_p    <= 1'b0;
        end else begin
            r_meta <= btn_r;
            s_r    <= r_meta;
            p_meta <= btn_p;
            s_p    <= p_meta;
        end
    end

    stopwatch_input_db #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s_r),
        .level (r_level),
        .press (r_press)
    );

    stopwatch_input_db #(.DB_CYCLES(DB_CYCLES)) u_db_p (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s_p),
        .level (p_level),
        .press (p_press)
    );

    // R wins: a pending or simultaneous R event swallows any P press
    assign p_take = p_press && !r_evt && !r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt <= 1'b0;
            p_evt <= 1'b0;
        end else begin
            if (r_press)             r_evt <= 1'b1;
            else if (d_tick && r_evt) r_evt <= 1'b0;
            if (p_take)              p_evt <= 1'b1;
            else if (d_tick && p_evt) p_evt <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cnt  <= '0;
            c_tick <= 1'b0;
            d_cnt  <= '0;
            d_tick <= 1'b0;
        end else begin
            c_cnt  <= (c_cnt == C_LAST) ? '0 : c_cnt + CW'(1);
            c_tick <= (c_cnt == C_LAST);
            d_cnt  <= (d_cnt == D_LAST) ? '0 : d_cnt + DDW'(1);
            d_tick <= (d_cnt == D_LAST);
        end
    end
endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Bench for stopwatch_input_ctrl: directed scenarios plus random bouncy buttons,
// all cycles compared against a run-length reference model.

module tb_stopwatch_input_ctrl;
    localparam int DB_CYCLES = 4;
    localparam int CNT_DIV   = 10;
    localparam int DISP_DIV  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_r = 1'b0;
    logic btn_p = 1'b0;
    logic r_level, p_level, r_evt, p_evt, c_tick, d_tick;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic m_r1, m_r2, m_p1, m_p2;
    logic m_rl, m_pl, m_revt, m_pevt, m_ct, m_dt;
    int   m_rrun, m_prun, m_cyc;

    stopwatch_input_ctrl #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_DIV   (CNT_DIV),
        .DISP_DIV  (DISP_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_r   (btn_r),
        .btn_p   (btn_p),
        .r_level (r_level),
        .p_level (p_level),
        .r_evt   (r_evt),
        .p_evt   (p_evt),
        .c_tick  (c_tick),
        .d_tick  (d_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r1 = 0; m_r2 = 0; m_p1 = 0; m_p2 = 0;
        m_rl = 0; m_pl = 0; m_revt = 0; m_pevt = 0;
        m_ct = 0; m_dt = 0;
        m_rrun = 0; m_prun = 0; m_cyc = 0;
    endtask

    // A level flips once the synchronised input has disagreed with it for
    // DB_CYCLES+1 consecutive samples; a 0->1 flip is a press.
    task automatic model_db(input logic s, inout logic lvl, inout int run, output logic strobe);
        strobe = 1'b0;
        if (s != lvl) begin
            run++;
            if (run == DB_CYCLES + 1) begin
                lvl    = s;
                run    = 0;
                strobe = s;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_step(input logic br, input logic bp);
        logic sr, sp, rs, ps, take_p, nr, np;
        sr = m_r2; sp = m_p2;
        m_r2 = m_r1; m_r1 = br;
        m_p2 = m_p1; m_p1 = bp;
        model_db(sr, m_rl, m_rrun, rs);
        model_db(sp, m_pl, m_prun, ps);
        take_p = ps && !m_revt && !rs;
        nr = rs ? 1'b1 : ((m_dt && m_revt) ? 1'b0 : m_revt);
        np = take_p ? 1'b1 : ((m_dt && m_pevt) ? 1'b0 : m_pevt);
        m_revt = nr;
        m_pevt = np;
        m_cyc++;
        m_ct = (m_cyc % CNT_DIV == 0);
        m_dt = (m_cyc % DISP_DIV == 0);
    endtask

    task automatic compare_all();
        check("r_level", r_level, m_rl);
        check("p_level", p_level, m_pl);
        check("r_evt",   r_evt,   m_revt);
        check("p_evt",   p_evt,   m_pevt);
        check("c_tick",  c_tick,  m_ct);
        check("d_tick",  d_tick,  m_dt);
    endtask

    // drive at negedge, model at posedge, compare at the following negedge
    task automatic cycle(input logic br, input logic bp);
        btn_r = br;
        btn_p = bp;
        @(posedge clk);
        model_step(br, bp);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_r_level", r_level, 0);
        check("rst_p_level", p_level, 0);
        check("rst_r_evt",   r_evt,   0);
        check("rst_p_evt",   p_evt,   0);
        check("rst_c_tick",  c_tick,  0);
        check("rst_d_tick",  d_tick,  0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        compare_all();
    endtask

    initial begin
        int ct_hits, dt_hits, first_idx, fall_idx, rises, hi_cnt;
        logic prev, seen_r, seen_p, vr, vp;
        logic [9:0] bounce;

        model_reset();
        @(negedge clk);
        do_reset();

        // idle: only ticks move
        ct_hits = 0; dt_hits = 0; first_idx = 0;
        for (int i = 1; i <= 50; i++) begin
            cycle(0, 0);
            if (c_tick) ct_hits++;
            if (d_tick) dt_hits++;
            if (d_tick && first_idx == 0) first_idx = i;
        end
        check("idle_ctick_count", ct_hits, 5);
        check("idle_dtick_count", dt_hits, 16);
        check("idle_first_dtick", first_idx, 3);

        // clean P press and release
        first_idx = 0; fall_idx = 0; rises = 0; prev = p_evt;
        for (int i = 1; i <= 40; i++) begin
            cycle(0, (i <= 20));
            if (p_level && first_idx == 0) first_idx = i;
            if (!p_level && first_idx != 0 && i > 20 && fall_idx == 0) fall_idx = i - 20;
            if (p_evt && !prev) rises++;
            prev = p_evt;
        end
        check("clean_rise_latency", first_idx, 7);
        check("clean_fall_latency", fall_idx, 7);
        check("clean_evt_count", rises, 1);

        // bouncy P press
        bounce = 10'b1111101101;
        first_idx = 0; rises = 0; prev = p_evt;
        for (int i = 1; i <= 30; i++) begin
            vp = (i <= 10) ? bounce[i-1] : (i <= 20);
            cycle(0, vp);
            if (p_level && first_idx == 0) first_idx = i;
            if (p_evt && !prev) rises++;
            prev = p_evt;
        end
        for (int i = 0; i < 12; i++) cycle(0, 0);
        check("bounce_rise_idx", first_idx, 12);
        check("bounce_evt_count", rises, 1);

        // simultaneous R and P
        seen_r = 0; seen_p = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1);
            if (r_evt) seen_r = 1;
            if (p_evt) seen_p = 1;
        end
        check("same_r_level", r_level, 1);
        check("same_p_level", p_level, 1);
        check("same_r_evt_seen", seen_r, 1);
        check("same_p_evt_seen", seen_p, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0);

        // P strobe lands on a d_tick cycle
        for (int i = 0; i < 3 && (m_cyc % DISP_DIV) != 0; i++) cycle(0, 0);
        hi_cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            cycle(0, 1);
            if (i == 6) check("align_dtick", d_tick, 1);
            if (p_evt) hi_cnt++;
        end
        check("align_evt_width", hi_cnt, 3);
        for (int i = 0; i < 12; i++) cycle(0, 0);

        // async reset with P event pending and R mid-debounce
        for (int i = 1; i <= 7; i++) cycle((i >= 4), 1);
        check("pre_rst_p_evt", p_evt, 1);
        do_reset();
        first_idx = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 0);
            if (c_tick && first_idx == 0) first_idx = i;
        end
        check("post_rst_first_ctick", first_idx, 10);

        // random bouncy buttons
        vr = 0; vp = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) vr = !vr;
            if ($urandom_range(0, 5) == 0) vp = !vp;
            cycle(vr, vp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
